memory_cell_reader: RTL and testbench

//   Read-side sequencer for the memory_cell activation store (port B).
//   On a start command, reads len consecutive words from base, wrapping at
//   the store depth. Issues addr_b and captures o_b after its 1-cycle

---
 rtl/memory_cell_reader_pkg.sv | 19 +
 rtl/memory_cell_reader_skid_fifo2.sv | 47 ++++
 rtl/memory_cell_reader.sv | 133 +++++++++++++
 tb/tb_memory_cell_reader.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_cell_reader_pkg.sv
// Shared defaults and FSM encoding for the memory_cell port-B read sequencer.
package memory_cell_reader_pkg;

  localparam int DEF_ADDR     = 12;
  localparam int DEF_WIDTH    = 32;
  localparam int DEF_NUM      = 53 * 53;
  localparam int DEF_TIMESTEP = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic int depth_of(input int num, input int timestep);
    return num * timestep;
  endfunction

endpackage

// File: rtl/memory_cell_reader_skid_fifo2.sv
// Two-entry output FIFO; the head entry drives the stream directly.
module memory_cell_reader_skid_fifo2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != 2'd0);
  assign o_count = r_count;

endmodule

// File: rtl/memory_cell_reader.sv
// Port-B read sequencer: streams len words from base (wrapping at DEPTH) out of
// the 1-cycle-latency memory_cell through a 2-entry FIFO with full backpressure.
module memory_cell_reader
  import memory_cell_reader_pkg::*;
#(
  parameter int ADDR     = DEF_ADDR,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NUM      = DEF_NUM,
  parameter int TIMESTEP = DEF_TIMESTEP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ADDR-1:0]  base,
  input  logic [ADDR:0]    len,
  output logic [ADDR-1:0]  addr_b,
  input  logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             o_ready,
  output logic             busy,
  output logic             done
);

  localparam int              DEPTH   = depth_of(NUM, TIMESTEP);
  localparam logic [ADDR+1:0] L_DEPTH = (ADDR+2)'(DEPTH);

  state_t          r_state;
  logic [ADDR-1:0] r_base;
  logic [ADDR:0]   r_len;
  logic [ADDR:0]   r_idx;
  logic [ADDR-1:0] r_addr;
  logic            r_iss;
  logic            r_pend;
  logic            r_busy;
  logic            r_done;

  logic [1:0]      w_count;
  logic            w_pop;
  logic            w_push;
  logic [2:0]      w_count_after;
  logic            w_can_issue;
  logic [ADDR+1:0] w_sum;
  logic [ADDR-1:0] w_next_addr;

  // r_iss: address presented, memory samples it at the next edge.
  // r_pend: rd_data holds an unpushed word; while no new read is issued the
  // address is held, so rd_data keeps re-reading that word and acts as a stall slot.
  assign w_pop         = o_valid & o_ready;
  assign w_push        = r_pend & ((w_count != 2'd2) | w_pop);
  assign w_count_after = {1'b0, w_count} + {2'b00, w_push} - {2'b00, w_pop};
  assign w_can_issue   = (w_count_after <= 3'd1);

  assign w_sum = {2'b00, r_base} + {1'b0, r_idx};

  always_comb begin
    w_next_addr = ADDR'(w_sum);
    if (w_sum >= L_DEPTH) begin
      w_next_addr = ADDR'(w_sum - L_DEPTH);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_base  <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_addr  <= '0;
      r_iss   <= 1'b0;
      r_pend  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_iss  <= 1'b0;
      r_pend <= r_iss | (r_pend & ~w_push);
      case (r_state)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_base  <= base;
              r_len   <= len;
              r_addr  <= base;
              r_idx   <= (ADDR+1)'(1);
              r_iss   <= 1'b1;
              r_busy  <= 1'b1;
              r_state <= (len == (ADDR+1)'(1)) ? DRAIN : RUN;
            end
          end
        end
        RUN: begin
          if (w_can_issue) begin
            r_addr <= w_next_addr;
            r_idx  <= r_idx + (ADDR+1)'(1);
            r_iss  <= 1'b1;
            if (r_idx + (ADDR+1)'(1) == r_len) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!r_iss && !r_pend && w_count == 2'd0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  memory_cell_reader_skid_fifo2 #(
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (rd_data),
    .i_pop   (w_pop),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_count (w_count)
  );

  assign addr_b = r_addr;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_memory_cell_reader.sv
// Bench for memory_cell_reader: memory preloaded with mem[a] = a, stream
// compared against (base + i) mod DEPTH.
module tb_memory_cell_reader;

  localparam int ADDR  = 12;
  localparam int WIDTH = 32;
  localparam int DEPTH = 53 * 53;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [ADDR-1:0]  base = '0;
  logic [ADDR:0]    len = '0;
  logic [ADDR-1:0]  addr_b;
  logic [WIDTH-1:0] rd_data = '0;
  logic [WIDTH-1:0] o_data;
  logic             o_valid;
  logic             o_ready = 1'b0;
  logic             busy;
  logic             done;

  int checks = 0;
  int failures = 0;

  int got[$];
  int hs_cyc[$];
  int addrs[$];
  int first_valid;
  int done_cnt;
  int done_cyc;
  int stall_err;
  int timed_out;

  memory_cell_reader dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .base    (base),
    .len     (len),
    .addr_b  (addr_b),
    .rd_data (rd_data),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // memory_cell port B: registered read of mem[a] = a
  always @(posedge clk) rd_data <= WIDTH'(addr_b);

  function automatic logic ready_of(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 3 == 0);
    return 1'($urandom_range(0, 1));
  endfunction

  // Cycle k of the run is sampled 1 time unit after edge k; edge 0 accepts start.
  task automatic run_stream(input int b, input int l, input int mode, input bit inject);
    logic             prev_stall;
    logic [WIDTH-1:0] prev_data;
    int               tail;
    got.delete(); hs_cyc.delete(); addrs.delete();
    first_valid = -1; done_cnt = 0; done_cyc = -1; stall_err = 0; timed_out = 0;
    prev_stall = 1'b0; prev_data = '0; tail = -1;
    @(negedge clk);
    base = ADDR'(b); len = (ADDR+1)'(l); start = 1'b1; o_ready = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 0) start = 1'b0;
      if (inject && cyc == 3) begin start = 1'b1; base = ADDR'(100); len = (ADDR+1)'(3); end
      if (inject && cyc == 4) start = 1'b0;
      if (addrs.size() == 0 || addrs[$] != int'(addr_b)) addrs.push_back(int'(addr_b));
      if (o_valid && first_valid < 0) first_valid = cyc;
      if (prev_stall && !(o_valid && o_data === prev_data)) stall_err++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (tail < 0) tail = cyc + 3;
      end
      o_ready = ready_of(mode, cyc);
      if (o_valid && o_ready) begin
        got.push_back(int'(o_data));
        hs_cyc.push_back(cyc);
      end
      prev_stall = o_valid && !o_ready;
      prev_data  = o_data;
      if (tail >= 0 && cyc >= tail) break;
    end
    if (tail < 0) timed_out = 1;
    o_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({o_valid, busy, done} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags: valid/busy/done=%b expected 000", {o_valid, busy, done});
    end
    checks++;
    if (addr_b !== '0 || o_data !== '0) begin
      failures++;
      $display("FAIL reset_data: addr_b=%0d o_data=%0d expected 0/0", addr_b, o_data);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    run_stream(0, 4, 0, 1'b0);
    $display("basic: words=%0d first_valid=%0d done_cnt=%0d", got.size(), first_valid, done_cnt);
    checks++;
    if (timed_out != 0 || got.size() != 4) begin
      failures++;
      $display("FAIL basic_count: got %0d words timeout=%0d expected 4 words", got.size(), timed_out);
    end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      checks++;
      if (got[i] != i) begin
        failures++;
        $display("FAIL basic_word[%0d]: got %0d expected %0d", i, got[i], i);
      end
    end
    checks++;
    if (first_valid != 2) begin
      failures++;
      $display("FAIL basic_latency: first o_valid cycle %0d expected 2", first_valid);
    end
    checks++;
    if (hs_cyc.size() != 4 || hs_cyc[hs_cyc.size()-1] - hs_cyc[0] != 3) begin
      failures++;
      $display("FAIL basic_throughput: %0d handshakes not on 4 consecutive cycles", hs_cyc.size());
    end
    checks++;
    if (done_cnt != 1 || hs_cyc.size() == 0 || done_cyc <= hs_cyc[hs_cyc.size()-1]) begin
      failures++;
      $display("FAIL basic_done: done pulses %0d at cycle %0d expected one after last word", done_cnt, done_cyc);
    end
    checks++;
    if (busy !== 1'b0 || o_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle: busy=%b o_valid=%b expected 0/0", busy, o_valid);
    end
  endtask

  task automatic test_wrap();
    int exp_a[6];
    exp_a = '{2805, 2806, 2807, 2808, 0, 1};
    run_stream(2805, 6, 0, 1'b0);
    $display("wrap: words=%0d addrs=%0d", got.size(), addrs.size());
    checks++;
    if (timed_out != 0 || addrs.size() != 6 || got.size() != 6) begin
      failures++;
      $display("FAIL wrap_count: addrs=%0d words=%0d timeout=%0d expected 6/6", addrs.size(), got.size(), timed_out);
    end
    for (int i = 0; i < 6; i++) begin
      if (i < addrs.size()) begin
        checks++;
        if (addrs[i] != exp_a[i]) begin
          failures++;
          $display("FAIL wrap_addr[%0d]: got %0d expected %0d", i, addrs[i], exp_a[i]);
        end
      end
      if (i < got.size()) begin
        checks++;
        if (got[i] != exp_a[i]) begin
          failures++;
          $display("FAIL wrap_word[%0d]: got %0d expected %0d", i, got[i], exp_a[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    run_stream(10, 8, 1, 1'b0);
    $display("backpressure: words=%0d stall_err=%0d", got.size(), stall_err);
    checks++;
    if (timed_out != 0 || got.size() != 8) begin
      failures++;
      $display("FAIL bp_count: got %0d words timeout=%0d expected 8", got.size(), timed_out);
    end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      checks++;
      if (got[i] != 10 + i) begin
        failures++;
        $display("FAIL bp_word[%0d]: got %0d expected %0d", i, got[i], 10 + i);
      end
    end
    checks++;
    if (stall_err != 0 || done_cnt != 1) begin
      failures++;
      $display("FAIL bp_stable: stall errors %0d done pulses %0d expected 0/1", stall_err, done_cnt);
    end
  endtask

  task automatic test_len_zero();
    @(negedge clk);
    base = ADDR'(5); len = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    $display("len_zero: done=%b busy=%b valid=%b", done, busy, o_valid);
    checks++;
    if ({done, busy, o_valid} !== 3'b100) begin
      failures++;
      $display("FAIL len0_pulse: done/busy/valid=%b expected 100", {done, busy, o_valid});
    end
    @(posedge clk); #1;
    checks++;
    if ({done, busy, o_valid} !== 3'b000) begin
      failures++;
      $display("FAIL len0_after: done/busy/valid=%b expected 000", {done, busy, o_valid});
    end
  endtask

  task automatic test_start_while_busy();
    run_stream(40, 6, 0, 1'b1);
    $display("start_while_busy: words=%0d done_cnt=%0d", got.size(), done_cnt);
    checks++;
    if (timed_out != 0 || got.size() != 6 || done_cnt != 1) begin
      failures++;
      $display("FAIL busy_start_count: words %0d done pulses %0d expected 6/1", got.size(), done_cnt);
    end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      checks++;
      if (got[i] != 40 + i) begin
        failures++;
        $display("FAIL busy_start_word[%0d]: got %0d expected %0d", i, got[i], 40 + i);
      end
    end
  endtask

  task automatic test_reset_midop();
    int hs;
    int dseen;
    hs = 0; dseen = 0;
    @(negedge clk);
    base = ADDR'(20); len = (ADDR+1)'(5); start = 1'b1; o_ready = 1'b1;
    for (int cyc = 0; cyc < 50 && hs < 2; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (o_valid && o_ready) hs++;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    $display("reset_midop: handshakes=%0d valid=%b busy=%b", hs, o_valid, busy);
    checks++;
    if (hs != 2 || {o_valid, busy, done} !== 3'b000 || addr_b !== '0 || o_data !== '0) begin
      failures++;
      $display("FAIL midop_reset: hs=%0d valid/busy/done=%b addr_b=%0d o_data=%0d expected 2,000,0,0",
               hs, {o_valid, busy, done}, addr_b, o_data);
    end
    repeat (3) begin
      @(posedge clk); #1;
      if (done) dseen++;
    end
    o_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (done) dseen++;
    end
    checks++;
    if (dseen != 0) begin
      failures++;
      $display("FAIL midop_no_done: done seen %0d times expected 0", dseen);
    end
    run_stream(0, 2, 0, 1'b0);
    checks++;
    if (timed_out != 0 || got.size() != 2 || got[0] != 0 || got[1] != 1) begin
      failures++;
      $display("FAIL midop_restart: got %0d words (first %0d) expected 0,1",
               got.size(), (got.size() > 0) ? got[0] : -1);
    end
  endtask

  task automatic test_random();
    int b;
    int l;
    for (int it = 0; it < 8; it++) begin
      b = (it % 2 == 0) ? $urandom_range(0, DEPTH - 1) : DEPTH - $urandom_range(1, 10);
      l = $urandom_range(1, 20);
      run_stream(b, l, 2, 1'b0);
      $display("random[%0d]: base=%0d len=%0d words=%0d stall_err=%0d", it, b, l, got.size(), stall_err);
      checks++;
      if (timed_out != 0 || got.size() != l || stall_err != 0 || done_cnt != 1) begin
        failures++;
        $display("FAIL rand_run[%0d]: words %0d/%0d stall_err %0d done %0d timeout %0d",
                 it, got.size(), l, stall_err, done_cnt, timed_out);
      end
      for (int i = 0; i < got.size() && i < l; i++) begin
        checks++;
        if (got[i] != (b + i) % DEPTH) begin
          failures++;
          $display("FAIL rand_word[%0d][%0d]: got %0d expected %0d", it, i, got[i], (b + i) % DEPTH);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    run_stream(7, 3, 0, 1'b0);
    checks++;
    if (got.size() != 3 || got[0] != 7 || got[2] != 9) begin
      failures++;
      $display("FAIL b2b_first: %0d words, expected 7..9", got.size());
    end
    run_stream(2808, 3, 0, 1'b0);
    checks++;
    if (got.size() != 3 || got[0] != 2808 || got[1] != 0 || got[2] != 1) begin
      failures++;
      $display("FAIL b2b_second: %0d words, expected 2808,0,1", got.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len_zero();
    test_start_while_busy();
    test_reset_midop();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
